// File: rtl/ppm_pkg.sv
// Shared definitions for the 4-PPM byte transmitter: FSM encoding and symbol geometry.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    GUARD = 2'd2
  } ppm_state_t;

  localparam int SYMS_PER_BYTE = 4;
  localparam int SLOTS_PER_SYM = 4;

  // Line is high only in the slot whose index equals the two-bit symbol value.
  function automatic logic slot_hit(input logic [1:0] sym, input logic [1:0] slot);
    return sym == slot;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Free-running slot timer: one-cycle slot_end tick every SLOT_CYCLES clocks while enabled.
module ppm_slot_timer #(
  parameter int SLOT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic slot_end
);

  localparam int CNT_W = $clog2(SLOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Disabled timer is held at zero so every new byte starts on a full slot.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_end = en && (cnt == LAST);

endmodule

// File: rtl/ppm_shift_two.sv
// 4-PPM byte transmitter: four two-bit symbols MSB-first, four slots each.
// Define PPM_GUARD_EN to insert GUARD_SLOTS low slots after every symbol.
module ppm_shift_two
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int GUARD_SLOTS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [7:0] din,
  output logic       ppm_out,
  output logic       busy,
  output logic       data_send_done
);

  localparam logic [1:0] LAST_SLOT = 2'(SLOTS_PER_SYM - 1);
  localparam logic [1:0] LAST_SYM  = 2'(SYMS_PER_BYTE - 1);

  if (SLOT_CYCLES < 1 || SLOT_CYCLES > 255) begin : g_bad_slot_cycles
    $error("SLOT_CYCLES must be in 1..255");
  end
  if (GUARD_SLOTS < 1 || GUARD_SLOTS > 4) begin : g_bad_guard_slots
    $error("GUARD_SLOTS must be in 1..4");
  end

  ppm_state_t state;
  logic [7:0] shreg;
  logic [1:0] slot_idx;
  logic [1:0] sym_idx;
  logic       slot_end;
  logic       sym_done;

  ppm_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .slot_end (slot_end)
  );

`ifdef PPM_GUARD_EN
  localparam int GCNT_W = (GUARD_SLOTS > 1) ? $clog2(GUARD_SLOTS) : 1;
  localparam logic [GCNT_W-1:0] LAST_GUARD = GCNT_W'(GUARD_SLOTS - 1);

  logic [GCNT_W-1:0] guard_cnt;

  assign sym_done = (state == GUARD) && slot_end && (guard_cnt == LAST_GUARD);
`else
  assign sym_done = (state == SLOT) && slot_end && (slot_idx == LAST_SLOT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      slot_idx       <= '0;
      sym_idx        <= '0;
      ppm_out        <= 1'b0;
      busy           <= 1'b0;
      data_send_done <= 1'b0;
`ifdef PPM_GUARD_EN
      guard_cnt      <= '0;
`endif
    end else begin
      data_send_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            shreg    <= din;
            slot_idx <= '0;
            sym_idx  <= '0;
            state    <= SLOT;
            busy     <= 1'b1;
            ppm_out  <= slot_hit(din[7:6], 2'd0);
          end
        end
        SLOT: begin
          if (slot_end && slot_idx != LAST_SLOT) begin
            slot_idx <= slot_idx + 2'd1;
            ppm_out  <= slot_hit(shreg[7:6], slot_idx + 2'd1);
          end
`ifdef PPM_GUARD_EN
          else if (slot_end) begin
            state     <= GUARD;
            guard_cnt <= '0;
            ppm_out   <= 1'b0;
          end
`endif
        end
`ifdef PPM_GUARD_EN
        GUARD: begin
          if (slot_end && guard_cnt != LAST_GUARD) begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      // End of a symbol (last slot, or last guard slot): next symbol or finish the byte.
      if (sym_done) begin
        if (sym_idx == LAST_SYM) begin
          state          <= IDLE;
          busy           <= 1'b0;
          ppm_out        <= 1'b0;
          data_send_done <= 1'b1;
        end else begin
          state    <= SLOT;
          sym_idx  <= sym_idx + 2'd1;
          slot_idx <= '0;
          shreg    <= {shreg[5:0], 2'b00};
          ppm_out  <= slot_hit(shreg[5:4], 2'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ppm_shift_two.sv
// Scoreboard bench for ppm_shift_two: a timing model queues expected bytes, a monitor checks line waveforms.
module tb_ppm_shift_two;

  localparam int SC   = 4;
  localparam int GS   = 1;
  localparam int SYMS = 4;
`ifdef PPM_GUARD_EN
  localparam int GE = GS;
`else
  localparam int GE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe, strobe1;
  logic [7:0] din, din1;
  logic       ppm_out, busy, data_send_done;
  logic       ppm_out1, busy1, done1;

  ppm_shift_two #(.SLOT_CYCLES(SC), .GUARD_SLOTS(GS)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .din(din),
    .ppm_out(ppm_out), .busy(busy), .data_send_done(data_send_done)
  );

  ppm_shift_two #(.SLOT_CYCLES(1), .GUARD_SLOTS(GS)) dut1 (
    .clk(clk), .rst(rst), .strobe(strobe1), .din(din1),
    .ppm_out(ppm_out1), .busy(busy1), .data_send_done(done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } item_t;

  item_t exp_q[$];
  int    cyc = 0;
  int    next_free = 0;

  function automatic int byte_len(int sc);
    return SYMS * (4 + GE) * sc;
  endfunction

  // Expected line level at offset i (0-based) into a byte's busy window.
  function automatic bit exp_bit(logic [7:0] d, int sc, int i);
    int symlen;
    int sym;
    int slot;
    int val;
    symlen = (4 + GE) * sc;
    sym    = i / symlen;
    slot   = (i % symlen) / sc;
    val    = (int'(d) >> (6 - 2 * sym)) & 3;
    return (slot < 4) && (slot == val);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: a byte occupies cycles acc+1..acc+L; the next strobe is taken from acc+L+1.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      next_free = 0;
    end else if (strobe && cyc >= next_free) begin
      exp_q.push_back('{din, cyc});
      next_free = cyc + byte_len(SC) + 1;
    end
    cyc++;
  end

  bit    cap[$];
  int    first_busy = -1;
  item_t e;
  int    bad;

  always @(negedge clk) begin
    if (rst) begin
      cap.delete();
      first_busy = -1;
    end else begin
      if (busy) begin
        if (cap.size() == 0) first_busy = cyc;
        cap.push_back(ppm_out);
      end else begin
        check("idle_line_low", int'(ppm_out), 0);
      end
      if (data_send_done) begin
        check("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          bad = 0;
          check("busy_len", cap.size(), byte_len(SC));
          for (int i = 0; i < cap.size(); i++)
            if (cap[i] != exp_bit(e.d, SC, i)) bad++;
          check("wave_bad_cycles", bad, 0);
          check("start_cycle", first_busy, e.acc + 1);
          check("done_cycle", cyc, e.acc + byte_len(SC) + 1);
          check("busy_at_done", int'(busy), 0);
        end
        cap.delete();
        first_busy = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d);
    strobe = 1'b1;
    din    = d;
    tick();
    strobe = 1'b0;
    din    = 8'($urandom);
  endtask

  task automatic wait_drain(int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", int'(n < bound), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; strobe = 1'b0; din = 8'h00; strobe1 = 1'b0; din1 = 8'h00;
    repeat (3) tick();
    check("rst_ppm_out", int'(ppm_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(data_send_done), 0);
    check("rst_busy1", int'(busy1), 0);
    rst = 1'b0;
    tick();

    send(8'h1B);
    wait_drain(200);

    send(8'hFF);
    repeat (9) tick();
    strobe = 1'b1; din = 8'h00;
    tick();
    strobe = 1'b0;
    wait_drain(200);

    send(8'h5A);
    n = 0;
    while (!data_send_done && n < 200) begin tick(); n++; end
    check("prior_done_seen", int'(n < 200), 1);
    strobe = 1'b1; din = 8'hE4;
    tick();
    strobe = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_slot0_high", int'(ppm_out), 0);
    wait_drain(200);

    send(8'hC3);
    repeat (29) tick();
    rst = 1'b1; strobe = 1'b1; din = 8'h00;
    tick();
    rst = 1'b0; strobe = 1'b0;
    check("abort_ppm_out", int'(ppm_out), 0);
    check("abort_busy", int'(busy), 0);
    repeat (100) tick();
    send(8'h96);
    wait_drain(200);

    for (int k = 0; k < 1500; k++) begin
      rst    = ($urandom_range(0, 399) == 0);
      strobe = ($urandom_range(0, 9) == 0);
      din    = 8'($urandom);
      tick();
    end
    rst = 1'b0; strobe = 1'b0;
    tick();
    wait_drain(300);

    strobe1 = 1'b1; din1 = 8'h1B;
    tick();
    strobe1 = 1'b0;
    for (int i = 0; i < byte_len(1); i++) begin
      check("sc1_line", int'(ppm_out1), int'(exp_bit(8'h1B, 1, i)));
      check("sc1_busy", int'(busy1), 1);
      tick();
    end
    check("sc1_done", int'(done1), 1);
    check("sc1_busy_end", int'(busy1), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
